dsp_systolic_feeder: RTL and testbench

- Stream front-end and back-end for a NUM-lane systolic multiply-accumulate chain of 18x18 DSPs.
- Accepts whole operand vectors over a valid/ready handshake and buffers them in an input FIFO.
- Drives each lane's ax/ay with the per-lane time skew the chain requires, and zero-fills idle cycles.
- Captures the chain's result at the matching latency into a credit-protected output FIFO, with its tag, behind a valid/ready handshake.

---
 rtl/dsp_systolic_feeder_if.sv | 33 +++
 rtl/dsp_systolic_feeder.sv | 198 +++++++++++++++++++
 tb/tb_dsp_systolic_feeder.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_systolic_feeder_if.sv
// rtl/dsp_systolic_feeder_if.sv - operand-in and result-out handshake bundle for dsp_systolic_feeder
//
// Signals:
//   in_valid/in_ready/in_ax/in_ay/in_tag   operand vector stream into the feeder
//   res_valid/res_ready/res_data/res_tag   result stream out of the feeder
// Modports: master = producer/consumer side, slave = feeder side.
interface dsp_systolic_feeder_if #(
    parameter int NUM            = 8,
    parameter int AX_WIDTH       = 18,
    parameter int AY_WIDTH       = 18,
    parameter int RESULT_A_WIDTH = 64,
    parameter int TAG_WIDTH      = 8
);
    logic                      in_valid;
    logic                      in_ready;
    logic [NUM*AX_WIDTH-1:0]   in_ax;
    logic [NUM*AY_WIDTH-1:0]   in_ay;
    logic [TAG_WIDTH-1:0]      in_tag;
    logic                      res_valid;
    logic                      res_ready;
    logic [RESULT_A_WIDTH-1:0] res_data;
    logic [TAG_WIDTH-1:0]      res_tag;

    modport master (
        output in_valid, in_ax, in_ay, in_tag, res_ready,
        input  in_ready, res_valid, res_data, res_tag
    );

    modport slave (
        input  in_valid, in_ax, in_ay, in_tag, res_ready,
        output in_ready, res_valid, res_data, res_tag
    );
endinterface

// File: rtl/dsp_systolic_feeder.sv
// rtl/dsp_systolic_feeder.sv - skewing front-end and credit-protected result back-end for a systolic MAC chain
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bus (slave)       operand vector stream in, tagged result stream out
//   ax[NUM], ay[NUM]  registered, per-lane skewed operands to the chain
//   chain_result      chain output, captured LAT+1 cycles after issue
//   busy              any vector buffered, in flight or unread
//   stat_issued, stat_credit_stall, stat_in_stall
//                     saturating 32-bit counters, present only with DSP_SYSTOLIC_FEEDER_STATS_EN
module dsp_systolic_feeder #(
    parameter int NUM            = 8,
    parameter int AX_WIDTH       = 18,
    parameter int AY_WIDTH       = 18,
    parameter int PIPELINE       = 3,
    parameter int RESULT_A_WIDTH = 64,
    parameter int TAG_WIDTH      = 8,
    parameter int IN_DEPTH       = 4,
    parameter int RES_DEPTH      = 4,
    parameter int LAT            = NUM + PIPELINE - 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    dsp_systolic_feeder_if.slave      bus,
    output logic [AX_WIDTH-1:0]       ax [NUM],
    output logic [AY_WIDTH-1:0]       ay [NUM],
    input  logic [RESULT_A_WIDTH-1:0] chain_result,
    output logic                      busy
`ifdef DSP_SYSTOLIC_FEEDER_STATS_EN
    ,
    output logic [31:0]               stat_issued,
    output logic [31:0]               stat_credit_stall,
    output logic [31:0]               stat_in_stall
`endif
);
    localparam int IN_AW  = $clog2(IN_DEPTH);
    localparam int RES_AW = $clog2(RES_DEPTH);
    localparam int IN_W   = TAG_WIDTH + NUM*AX_WIDTH + NUM*AY_WIDTH;
    localparam int RES_W  = TAG_WIDTH + RESULT_A_WIDTH;
    localparam logic [IN_AW:0]  IN_FULL   = (IN_AW+1)'(IN_DEPTH);
    localparam logic [RES_AW:0] CREDIT_INIT = (RES_AW+1)'(RES_DEPTH);

    if (NUM % 2 != 0) begin : g_chk_num
        $fatal(1, "dsp_systolic_feeder: NUM must be even");
    end
    if (PIPELINE < 2 || PIPELINE > 4) begin : g_chk_pipe
        $fatal(1, "dsp_systolic_feeder: PIPELINE must be 2..4");
    end
    if (IN_DEPTH < 2 || (IN_DEPTH & (IN_DEPTH - 1)) != 0) begin : g_chk_in
        $fatal(1, "dsp_systolic_feeder: IN_DEPTH must be a power of 2, at least 2");
    end
    if (RES_DEPTH < 2 || (RES_DEPTH & (RES_DEPTH - 1)) != 0) begin : g_chk_res
        $fatal(1, "dsp_systolic_feeder: RES_DEPTH must be a power of 2, at least 2");
    end

    // ---------------- input FIFO ----------------
    logic [IN_W-1:0]  in_mem [IN_DEPTH];
    logic [IN_AW-1:0] in_wr_ptr, in_rd_ptr;
    logic [IN_AW:0]   in_cnt;
    logic [RES_AW:0]  credits;
    logic             in_wr_en, issue;
    logic [IN_W-1:0]  head;
    logic [NUM*AX_WIDTH-1:0] head_ax;
    logic [NUM*AY_WIDTH-1:0] head_ay;
    logic [TAG_WIDTH-1:0]    head_tag;

    // Gated by rst_n so the producer sees not-ready for the whole reset.
    assign bus.in_ready = rst_n && (in_cnt != IN_FULL);
    assign in_wr_en     = bus.in_valid && bus.in_ready;
    assign issue        = (in_cnt != '0) && (credits != '0);

    assign head     = in_mem[in_rd_ptr];
    assign head_tag = head[IN_W-1 -: TAG_WIDTH];
    assign head_ax  = head[NUM*AY_WIDTH +: NUM*AX_WIDTH];
    assign head_ay  = head[0 +: NUM*AY_WIDTH];

    always_ff @(posedge clk) begin
        if (in_wr_en) in_mem[in_wr_ptr] <= {bus.in_tag, bus.in_ax, bus.in_ay};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_wr_ptr <= '0;
            in_rd_ptr <= '0;
            in_cnt    <= '0;
        end else begin
            if (in_wr_en) in_wr_ptr <= in_wr_ptr + 1'b1;
            if (issue)    in_rd_ptr <= in_rd_ptr + 1'b1;
            case ({in_wr_en, issue})
                2'b10:   in_cnt <= in_cnt + 1'b1;
                2'b01:   in_cnt <= in_cnt - 1'b1;
                default: in_cnt <= in_cnt;
            endcase
        end
    end

    // ---------------- skew lines ----------------
    // Lane k has k+1 stages so its operand reaches the chain k cycles after lane 0.
    // A cycle without issue loads zeros, so bubbles add nothing to the chain sum.
    for (genvar k = 0; k < NUM; k++) begin : g_lane
        logic [AX_WIDTH-1:0] xs [k+1];
        logic [AY_WIDTH-1:0] ys [k+1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int j = 0; j <= k; j++) begin
                    xs[j] <= '0;
                    ys[j] <= '0;
                end
            end else begin
                xs[0] <= issue ? head_ax[k*AX_WIDTH +: AX_WIDTH] : '0;
                ys[0] <= issue ? head_ay[k*AY_WIDTH +: AY_WIDTH] : '0;
                for (int j = 1; j <= k; j++) begin
                    xs[j] <= xs[j-1];
                    ys[j] <= ys[j-1];
                end
            end
        end

        assign ax[k] = xs[k];
        assign ay[k] = ys[k];
    end

    // ---------------- valid/tag tracking ----------------
    // Bit LAT is high in exactly the cycle the chain presents this vector's sum.
    logic [LAT:0]         vld_sr;
    logic [TAG_WIDTH-1:0] tag_sr [LAT+1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr <= '0;
            for (int j = 0; j <= LAT; j++) tag_sr[j] <= '0;
        end else begin
            vld_sr    <= {vld_sr[LAT-1:0], issue};
            tag_sr[0] <= head_tag;
            for (int j = 1; j <= LAT; j++) tag_sr[j] <= tag_sr[j-1];
        end
    end

    // ---------------- result FIFO and credits ----------------
    logic [RES_W-1:0]  res_mem [RES_DEPTH];
    logic [RES_AW-1:0] res_wr_ptr, res_rd_ptr;
    logic [RES_AW:0]   res_cnt;
    logic              res_wr, res_pop;

    assign res_wr        = vld_sr[LAT];
    assign bus.res_valid = (res_cnt != '0);
    assign res_pop       = bus.res_valid && bus.res_ready;
    assign bus.res_data  = bus.res_valid ? res_mem[res_rd_ptr][RESULT_A_WIDTH-1:0] : '0;
    assign bus.res_tag   = bus.res_valid ? res_mem[res_rd_ptr][RES_W-1 -: TAG_WIDTH] : '0;

    always_ff @(posedge clk) begin
        if (res_wr) res_mem[res_wr_ptr] <= {tag_sr[LAT], chain_result};
    end

    // Credits count free result slots not yet claimed by an issued vector,
    // so a captured chain result always has room.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_wr_ptr <= '0;
            res_rd_ptr <= '0;
            res_cnt    <= '0;
            credits    <= CREDIT_INIT;
        end else begin
            if (res_wr)  res_wr_ptr <= res_wr_ptr + 1'b1;
            if (res_pop) res_rd_ptr <= res_rd_ptr + 1'b1;
            case ({res_wr, res_pop})
                2'b10:   res_cnt <= res_cnt + 1'b1;
                2'b01:   res_cnt <= res_cnt - 1'b1;
                default: res_cnt <= res_cnt;
            endcase
            case ({issue, res_pop})
                2'b10:   credits <= credits - 1'b1;
                2'b01:   credits <= credits + 1'b1;
                default: credits <= credits;
            endcase
        end
    end

    assign busy = (in_cnt != '0) || (|vld_sr) || (res_cnt != '0);

`ifdef DSP_SYSTOLIC_FEEDER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued       <= '0;
            stat_credit_stall <= '0;
            stat_in_stall     <= '0;
        end else begin
            if (issue && stat_issued != '1)
                stat_issued <= stat_issued + 1'b1;
            if ((in_cnt != '0) && (credits == '0) && stat_credit_stall != '1)
                stat_credit_stall <= stat_credit_stall + 1'b1;
            if (bus.in_valid && !bus.in_ready && stat_in_stall != '1)
                stat_in_stall <= stat_in_stall + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_dsp_systolic_feeder.sv
// tb/tb_dsp_systolic_feeder.sv - self-checking bench for dsp_systolic_feeder with a systolic chain model
module tb_dsp_systolic_feeder;
    localparam int NUM  = 8;
    localparam int AXW  = 18;
    localparam int AYW  = 18;
    localparam int PIPE = 3;
    localparam int RW   = 64;
    localparam int TW   = 8;
    localparam int IND  = 4;
    localparam int RESD = 4;
    localparam int LAT  = NUM + PIPE - 1;
    localparam int HD   = 32;
    localparam int CW   = 160;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [AXW-1:0] ax [NUM];
    logic [AYW-1:0] ay [NUM];
    logic [RW-1:0]  chain_result = '0;
    logic           busy;
`ifdef DSP_SYSTOLIC_FEEDER_STATS_EN
    logic [31:0] stat_issued, stat_credit_stall, stat_in_stall;
`endif

    dsp_systolic_feeder_if #(.NUM(NUM), .AX_WIDTH(AXW), .AY_WIDTH(AYW),
                             .RESULT_A_WIDTH(RW), .TAG_WIDTH(TW)) bus ();

    dsp_systolic_feeder #(
        .NUM(NUM), .AX_WIDTH(AXW), .AY_WIDTH(AYW), .PIPELINE(PIPE),
        .RESULT_A_WIDTH(RW), .TAG_WIDTH(TW), .IN_DEPTH(IND), .RES_DEPTH(RESD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .ax(ax),
        .ay(ay),
        .chain_result(chain_result),
        .busy(busy)
`ifdef DSP_SYSTOLIC_FEEDER_STATS_EN
        ,
        .stat_issued(stat_issued),
        .stat_credit_stall(stat_credit_stall),
        .stat_in_stall(stat_in_stall)
`endif
    );

    always #5 clk = ~clk;

    // Chain model: the sum seen in cycle c is lane k's operand pair from cycle c-LAT+k.
    logic [AXW-1:0] hax [HD][NUM];
    logic [AYW-1:0] hay [HD][NUM];
    int cyc = 0;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        logic [63:0] s;
        int idx;
        for (int k = 0; k < NUM; k++) begin
            hax[cyc % HD][k] = ax[k];
            hay[cyc % HD][k] = ay[k];
        end
        s = '0;
        for (int k = 0; k < NUM; k++) begin
            idx = cyc - LAT + k;
            if (idx >= 1) s = s + 64'(hax[idx % HD][k]) * 64'(hay[idx % HD][k]);
        end
        chain_result = s;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int stall_cnt = 0;
    int pops = 0;
    bit acc = 1'b0;
    logic [TW+RW-1:0] exp_q [$];

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] dot(input logic [NUM*AXW-1:0] a, input logic [NUM*AYW-1:0] b);
        logic [63:0] s = '0;
        for (int k = 0; k < NUM; k++) s = s + 64'(a[k*AXW +: AXW]) * 64'(b[k*AYW +: AYW]);
        return s;
    endfunction

    function automatic logic [CW-1:0] pack_ax();
        logic [CW-1:0] p = '0;
        for (int k = 0; k < NUM; k++) p[k*AXW +: AXW] = ax[k];
        return p;
    endfunction

    function automatic logic [CW-1:0] pack_ay();
        logic [CW-1:0] p = '0;
        for (int k = 0; k < NUM; k++) p[k*AYW +: AYW] = ay[k];
        return p;
    endfunction

    function automatic logic [NUM*AXW-1:0] rand_vec();
        logic [NUM*AXW-1:0] v;
        for (int k = 0; k < NUM; k++) v[k*AXW +: AXW] = 18'($urandom);
        return v;
    endfunction

    // Evaluate both handshakes just before the edge, then advance one cycle.
    task automatic tick();
        logic [TW+RW-1:0] e;
        acc = 1'b0;
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back({bus.in_tag, dot(bus.in_ax, bus.in_ay)});
                acc = 1'b1;
            end
            if (bus.in_valid && !bus.in_ready) stall_cnt++;
            if (bus.res_valid && bus.res_ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    check("unexpected_result", CW'(exp_q.size()), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("res_data", CW'(bus.res_data), CW'(e[RW-1:0]));
                    check("res_tag", CW'(bus.res_tag), CW'(e[RW+TW-1 -: TW]));
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [NUM*AXW-1:0] a, input logic [NUM*AYW-1:0] b, input logic [TW-1:0] t);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_ax = a;
        bus.in_ay = b;
        bus.in_tag = t;
        acc = 1'b0;
        while (!acc && n < 200) begin
            tick();
            n++;
        end
        if (!acc) check("offer_timeout", CW'(acc), 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while (exp_q.size() > 0 && n < maxc) begin
            tick();
            n++;
        end
        check("drain_left", CW'(exp_q.size()), 0);
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        stall_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        logic [NUM*AXW-1:0] va;
        logic [NUM*AYW-1:0] vb;
        logic [CW-1:0] ex, ey;
        int nacc, n, rv_seen;

        bus.in_valid = 1'b0;
        bus.in_ax = '0;
        bus.in_ay = '0;
        bus.in_tag = '0;
        bus.res_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", CW'(bus.in_ready), 0);
        check("rst_ax", pack_ax(), 0);
        check("rst_ay", pack_ay(), 0);
        check("rst_res_valid", CW'(bus.res_valid), 0);
        check("rst_res_data", CW'(bus.res_data), 0);
        check("rst_res_tag", CW'(bus.res_tag), 0);
        check("rst_busy", CW'(busy), 0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", CW'(bus.in_ready), 1);

        // Single vector: ax=k+1, ay=2, tag 0x5A; verify the skew timing lane by lane
        bus.res_ready = 1'b1;
        for (int k = 0; k < NUM; k++) begin
            va[k*AXW +: AXW] = 18'(k + 1);
            vb[k*AYW +: AYW] = 18'd2;
        end
        pops = 0;
        offer(va, vb, 8'h5A);
        for (int j = 0; j < NUM + 2; j++) begin
            tick();
            ex = '0;
            ey = '0;
            for (int k = 0; k < NUM; k++) if (j == k) begin
                ex[k*AXW +: AXW] = 18'(k + 1);
                ey[k*AYW +: AYW] = 18'd2;
            end
            check($sformatf("skew_ax_%0d", j), pack_ax(), ex);
            check($sformatf("skew_ay_%0d", j), pack_ay(), ey);
        end
        n = 0;
        while (!bus.res_valid && n < 50) begin tick(); n++; end
        check("single_res_data", CW'(bus.res_data), 72);
        check("single_res_tag", CW'(bus.res_tag), 8'h5A);
        drain(50);
        check("single_pops", CW'(pops), 1);

        // 16 back-to-back random vectors
        pops = 0;
        for (int i = 0; i < 16; i++) offer(rand_vec(), rand_vec(), 8'($urandom));
        drain(300);
        check("burst_pops", CW'(pops), 16);
        check("burst_idle", CW'(busy), 0);

        // Back-pressure: res_ready=0, ten vectors offered
        do_reset();
        bus.res_ready = 1'b0;
        pops = 0;
        nacc = 0;
        bus.in_ax = rand_vec();
        bus.in_ay = rand_vec();
        bus.in_tag = 8'($urandom);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (acc) begin
                nacc++;
                bus.in_ax = rand_vec();
                bus.in_ay = rand_vec();
                bus.in_tag = 8'($urandom);
                if (nacc >= 10) bus.in_valid = 1'b0;
            end
        end
        check("bp_accepted", CW'(nacc), 8);
        check("bp_in_ready", CW'(bus.in_ready), 0);
        check("bp_res_valid", CW'(bus.res_valid), 1);
        check("bp_busy", CW'(busy), 1);
`ifdef DSP_SYSTOLIC_FEEDER_STATS_EN
        check("stat_issued_4", CW'(stat_issued), 4);
        check("stat_credit_stall_nz", CW'(stat_credit_stall != 0), 1);
        check("stat_in_stall_a", CW'(stat_in_stall), CW'(stall_cnt));
`endif
        bus.res_ready = 1'b1;
        n = 0;
        while ((nacc < 10 || exp_q.size() > 0) && n < 300) begin
            tick();
            n++;
            if (acc) begin
                nacc++;
                bus.in_ax = rand_vec();
                bus.in_ay = rand_vec();
                bus.in_tag = 8'($urandom);
                if (nacc >= 10) bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        check("bp_total_accepted", CW'(nacc), 10);
        check("bp_pops", CW'(pops), 10);
        check("bp_left", CW'(exp_q.size()), 0);
`ifdef DSP_SYSTOLIC_FEEDER_STATS_EN
        check("stat_issued_10", CW'(stat_issued), 10);
        check("stat_in_stall_b", CW'(stat_in_stall), CW'(stall_cnt));
`endif

        // Bubbles with all-ones operands
        pops = 0;
        va = '1;
        vb = '1;
        for (int i = 0; i < 6; i++) begin
            offer(va, vb, 8'(i));
            tick();
        end
        n = 0;
        while (!bus.res_valid && n < 50) begin tick(); n++; end
        check("bubble_first", CW'(bus.res_data), CW'(64'd8 * 64'd262143 * 64'd262143));
        drain(200);
        check("bubble_pops", CW'(pops), 6);

        // Reset with three vectors in flight
        pops = 0;
        for (int i = 0; i < 3; i++) offer(rand_vec(), rand_vec(), 8'($urandom));
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_ax", pack_ax(), 0);
        check("mid_rst_ay", pack_ay(), 0);
        check("mid_rst_busy", CW'(busy), 0);
        check("mid_rst_in_ready", CW'(bus.in_ready), 0);
        exp_q.delete();
        stall_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        rv_seen = 0;
        for (int c = 0; c < 25; c++) begin
            if (bus.res_valid) rv_seen++;
            tick();
        end
        check("mid_rst_no_result", CW'(rv_seen), 0);
        offer(rand_vec(), rand_vec(), 8'hC3);
        drain(60);
        check("mid_rst_new_pops", CW'(pops), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
